// File: rtl/uart_pkg.sv
// Shared types, constants and baud arithmetic for the UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load a full or half bit period, done when it reaches zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic half,
  output logic done
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_LOAD = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LOAD = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] count;

  // Loading N-1 makes done fire N cycles after the load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= half ? HALF_LOAD : FULL_LOAD;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent TX serialiser and RX deserialiser sharing clock and baud.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_send_trigger,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
);

  // Must be at least 4 so the half-period load stays non-zero.
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  // ---------------- transmitter ----------------
  uart_state_e          tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic [BIT_W-1:0]     tx_bit;
  logic                 tx_load;
  logic                 tx_done;

  always_comb begin
    tx_load = 1'b0;
    if (tx_state == IDLE) begin
      tx_load = tx_send_trigger;
    end else begin
      tx_load = tx_done;
    end
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .half (1'b0),
    .done (tx_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_send_trigger) begin
            tx_shift <= tx_data;
            tx_bit   <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= START;
          end else begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
          end
        end
        START: begin
          if (tx_done) begin
            tx       <= tx_shift[0];
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_done) begin
            if (tx_bit == LAST_BIT) begin
              tx       <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
              tx_bit   <= tx_bit + BIT_W'(1);
            end
          end
        end
        STOP: begin
          // A trigger on the closing edge chains the next frame with no idle gap.
          if (tx_done) begin
            if (tx_send_trigger) begin
              tx_shift <= tx_data;
              tx_bit   <= '0;
              tx       <= 1'b0;
              tx_state <= START;
            end else begin
              tx_busy  <= 1'b0;
              tx_state <= IDLE;
            end
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  uart_state_e          rx_state;
  logic [DATA_BITS-1:0] rx_shift;
  logic [BIT_W-1:0]     rx_bit;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_load;
  logic                 rx_half;
  logic                 rx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Entering START loads half a period so later samples land mid-bit.
  always_comb begin
    rx_load = 1'b0;
    rx_half = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_load = ~rx_sync;
        rx_half = 1'b1;
      end
      START:   rx_load = rx_done & ~rx_sync;
      DATA:    rx_load = rx_done;
      default: rx_load = 1'b0;
    endcase
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk  (clk),
    .rst  (rst),
    .load (rx_load),
    .half (rx_half),
    .done (rx_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state     <= IDLE;
      rx_shift     <= '0;
      rx_bit       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (!rx_sync) begin
            rx_state <= START;
          end
        end
        START: begin
          if (rx_done) begin
            if (!rx_sync) begin
              rx_bit   <= '0;
              rx_state <= DATA;
            end else begin
              rx_state <= IDLE;
            end
          end
        end
        DATA: begin
          if (rx_done) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + BIT_W'(1);
            if (rx_bit == LAST_BIT) begin
              rx_state <= STOP;
            end
          end
        end
        STOP: begin
          if (rx_done) begin
            if (rx_sync) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
            rx_state <= IDLE;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: frame-level reference model plus per-cycle comparison.
module tb_uart_transceiver;

  localparam int C    = 9;      // 1 MHz / 111111 baud
  localparam int HALF = C / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_send_trigger = 1'b0;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;
  logic       tx_busy, tx, rx, rx_valid, rx_frame_err;
  logic [7:0] rx_data;

  assign rx = loop_en ? tx : rx_drv;

  uart_transceiver #(.BAUD_RATE(111_111), .CLK_FREQ(1_000_000)) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_data         (tx_data),
    .tx_send_trigger (tx_send_trigger),
    .tx_busy         (tx_busy),
    .tx              (tx),
    .rx              (rx),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_frame_err    (rx_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
    longint     due;
  } exp_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_valid = 0;
  int         n_err = 0;
  longint     cyc = 0;
  longint     last_rst = -1;
  longint     t0 = -100000;
  longint     free_at = 0;
  bit         active = 1'b0;
  logic [7:0] tbyte = 8'h00;
  logic [7:0] last_good = 8'h00;
  exp_t       exq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Model: frame acceptance, latched byte and expected RX outcomes, evaluated per clock edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      active   = 1'b0;
      free_at  = cyc + 1;
      last_rst = cyc;
      exq.delete();
    end else if (tx_send_trigger && cyc >= free_at) begin
      t0      = cyc;
      tbyte   = tx_data;
      active  = 1'b1;
      free_at = cyc + 10 * C;
      if (loop_en) exq.push_back(exp_t'{err: 1'b0, data: tx_data, due: cyc + 3 + HALF + 9 * C});
    end
  end

  longint k;
  int     bi;
  logic   exp_tx, exp_busy;

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      if (last_rst == cyc) last_good = 8'h00;
      k = cyc - t0;
      if (active && k >= 0 && k < 10 * C) begin
        exp_busy = 1'b1;
        bi = int'(k / C);
        exp_tx = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : tbyte[bi-1];
      end else begin
        exp_busy = 1'b0;
        exp_tx   = 1'b1;
      end
      chk("tx", 32'(tx), 32'(exp_tx));
      chk("tx_busy", 32'(tx_busy), 32'(exp_busy));
      if (rx_valid === 1'b1 || rx_frame_err === 1'b1) begin
        if (rx_valid === 1'b1) n_valid++;
        if (rx_frame_err === 1'b1) n_err++;
        if (exq.size() == 0) begin
          chk("rx_unexpected_strobe", 32'({rx_valid, rx_frame_err}), 32'd0);
        end else begin
          chk("rx_strobe_kind", 32'({rx_valid, rx_frame_err}), exq[0].err ? 32'd1 : 32'd2);
          chk("rx_strobe_time", 32'(cyc + 2 >= exq[0].due && cyc <= exq[0].due + 2), 32'd1);
          if (!exq[0].err) last_good = exq[0].data;
          void'(exq.pop_front());
        end
      end else if (exq.size() > 0 && cyc > exq[0].due + 2) begin
        chk("rx_strobe_missing", 32'({rx_valid, rx_frame_err}), exq[0].err ? 32'd1 : 32'd2);
        void'(exq.pop_front());
      end
      chk("rx_data", 32'(rx_data), 32'(last_good));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    tx_data = b;
    tx_send_trigger = 1'b1;
    tick(1);
    tx_send_trigger = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    exq.push_back(exp_t'{err: ~stop, data: b, due: cyc + 3 + HALF + 9 * C});
    rx_drv = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(C);
    end
    rx_drv = stop;
    tick(C);
    rx_drv = 1'b1;
  endtask

  int         nv, ne, len, busy_cnt;
  int         runs[$];
  logic       levs[$];
  logic       prev;
  logic [9:0] pat;

  initial begin
    tick(4);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_frame_err", 32'(rx_frame_err), 32'd0);
    rst = 1'b0;
    tick(2);

    // 0x55 on the wire: alternating levels, each exactly one bit period.
    send_byte(8'h55);
    chk("tx_start_latency", 32'(tx), 32'd0);
    chk("busy_rise", 32'(tx_busy), 32'd1);
    prev = tx;
    len = 1;
    busy_cnt = 1;
    for (int i = 0; i < 11 * C; i++) begin
      tick(1);
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx === prev) len++;
      else begin
        runs.push_back(len);
        levs.push_back(prev);
        prev = tx;
        len = 1;
      end
    end
    pat = 10'h2AA;
    chk("level_count", 32'(runs.size()), 32'd9);
    for (int j = 0; j < 9 && j < runs.size(); j++) begin
      chk("level_len", 32'(runs[j]), 32'd9);
      chk("level_val", 32'(levs[j]), 32'(pat[j]));
    end
    chk("busy_len", 32'(busy_cnt), 32'd90);
    chk("loop_55", 32'(rx_data), 32'h55);

    // Loopback of every byte value.
    for (int v = 0; v < 256; v++) begin
      nv = n_valid;
      ne = n_err;
      send_byte(8'(v));
      tick(10 * C + 10);
      chk("loop_data", 32'(rx_data), 32'(v));
      chk("loop_valid_count", 32'(n_valid - nv), 32'd1);
      chk("loop_err_count", 32'(n_err - ne), 32'd0);
    end

    // Mid-frame retrigger with new data is ignored.
    nv = n_valid;
    send_byte(8'hA5);
    tick(4 * C);
    tx_data = 8'h3C;
    tx_send_trigger = 1'b1;
    tick(1);
    tx_send_trigger = 1'b0;
    tick(12 * C + 20);
    chk("retrig_data", 32'(rx_data), 32'hA5);
    chk("retrig_valid_count", 32'(n_valid - nv), 32'd1);

    // Short low glitch on rx, then a good frame.
    loop_en = 1'b0;
    nv = n_valid;
    ne = n_err;
    rx_drv = 1'b0;
    tick(3);
    rx_drv = 1'b1;
    tick(3 * C);
    chk("glitch_valid", 32'(n_valid - nv), 32'd0);
    chk("glitch_err", 32'(n_err - ne), 32'd0);
    drive_frame(8'h3C, 1'b1);
    tick(C);
    chk("after_glitch_data", 32'(rx_data), 32'h3C);

    // Stop bit low: error strobe, data held.
    ne = n_err;
    drive_frame(8'h81, 1'b0);
    tick(C + 2);
    chk("frame_err_count", 32'(n_err - ne), 32'd1);
    chk("frame_err_hold", 32'(rx_data), 32'h3C);

    for (int i = 0; i < 12; i++) begin
      drive_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
      tick(C + $urandom_range(0, 5));
    end

    // Reset during TX and RX data bits in loopback.
    loop_en = 1'b1;
    tick(C);
    nv = n_valid;
    ne = n_err;
    send_byte(8'h5A);
    tick(5 * C);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    tick(12 * C);
    chk("abort_valid", 32'(n_valid - nv), 32'd0);
    chk("abort_err", 32'(n_err - ne), 32'd0);
    send_byte(8'h7E);
    tick(10 * C + 10);
    chk("post_reset_data", 32'(rx_data), 32'h7E);

    // Random trigger holds: back-to-back frames latch tx_data at each acceptance edge.
    for (int i = 0; i < 30; i++) begin
      tx_send_trigger = 1'b1;
      for (int h = $urandom_range(1, 20 * C); h > 0; h--) begin
        tx_data = 8'($urandom_range(0, 255));
        tick(1);
      end
      tx_send_trigger = 1'b0;
      tick($urandom_range(0, 30));
    end
    for (int i = 0; i < 20 * C && exq.size() != 0; i++) tick(1);
    chk("drain", 32'(exq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Full-duplex 8N1 UART: a transmit engine serialising a parallel byte onto `tx`, and a receive engine deserialising `rx` into a parallel byte with a one-cycle valid strobe. The block sits between the board UART pins and on-chip logic. TX and RX share only clock, reset and baud parameters, so `tx` may be looped back to `rx` for self-test.

## Interface
- `BAUD_RATE`, default 115200: line bit rate in bits/s.
- `CLK_FREQ`, default 100_000_000: `clk` frequency in Hz.
- `CLKS_PER_BIT` (localparam) = `CLK_FREQ / BAUD_RATE`, integer division (868 at defaults). It must be at least 4.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `tx_data`  in  8: byte to send. Sampled only on an accepted trigger.
- `tx_send_trigger`  in  1: request to send `tx_data`. Level-sampled each cycle.
- `tx_busy`  out  1: high while a frame is in progress.
- `tx`  out  1: serial output, idle high.
- `rx`  in  1: serial input, asynchronous to `clk`.
- `rx_data`  out  8: last correctly framed byte received. Holds until the next good frame.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` updates.
- `rx_frame_err`  out  1: one-cycle pulse when the stop bit samples low.

## Operation
- Frame format: 1 start bit (0), 8 data bits sent LSB first, 1 stop bit (1). No parity.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `tx_send_trigger`=1, latch `tx_data` into a shift register, clear the bit counter, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- The trigger is ignored in every state except IDLE. A trigger held high starts back-to-back frames. The latched byte is immune to `tx_data` changes mid-frame.
- RX input path: 2-flop synchronizer on `rx`. All RX decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a synchronized 0, go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If the sample is 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), shifting into bit 7 downward so the byte assembles LSB-first. After 8 samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If 1, load `rx_data` and pulse `rx_valid`. If 0, pulse `rx_frame_err` and leave `rx_data` unchanged. Return to IDLE either way; a new start edge may then be seen immediately.
- Reset values: `tx`=1, `tx_busy`=0, `rx_data`=8'h00, `rx_valid`=0, `rx_frame_err`=0. Both FSMs go to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame: `tx` goes high the cycle after, and a partial RX byte is discarded with no strobes.

## Timing
- All outputs are registered.
- TX latency: trigger high at edge N → `tx`=0 and `tx_busy`=1 from edge N+1.
- TX frame length: exactly 10·CLKS_PER_BIT cycles, then `tx_busy` falls. A trigger sampled on that same edge starts the next frame with no idle bit.
- RX latency: `rx_valid` pulses about 9.5·CLKS_PER_BIT + 3 cycles after the falling start edge arrives on `rx`.
  - In loopback at defaults, `rx_data` is valid well within 10 bit times (86.8 µs) plus 1 µs from the trigger.
- Bit-period error comes from integer truncation only: ≤1 clk per bit, no accumulated drift beyond this.

## Structure
- Package `uart_pkg`: the `uart_state_e` enum (IDLE, START, DATA, STOP) shared by both FSMs, a `DATA_BITS=8` constant, and a `clks_per_bit(clk_freq, baud)` function.
- Sub-module `uart_bit_timer`: a CLKS_PER_BIT down-counter with a load and a terminal-count output, instantiated once in TX and once in RX. The RX instance loads CLKS_PER_BIT/2 in START.
- The TX and RX FSMs stay inline in `uart_transceiver`.

## Test plan
- Loopback (`tx`→`rx`), all 256 values 0x00..0xFF: one-cycle trigger, wait 10 bit times + 1 µs → `rx_data`==sent byte, exactly one `rx_valid` per frame, no `rx_frame_err`.
- Send 0x55 → `tx` shows 0,1,0,1,0,1,0,1,0,1. Each level lasts exactly 868 cycles. `tx_busy` is high for 8680 cycles.
- Pulse the trigger again 100 cycles into a 0xA5 frame with `tx_data`=0x3C → the frame completes as 0xA5 and no second frame follows.
- Drive `rx` low for 300 cycles then high → no `rx_valid`, no `rx_frame_err`, RX back in IDLE.
- Drive an RX frame 0x81 with the stop bit held low → `rx_frame_err` pulses once and `rx_data` keeps its previous value.
- Assert `rst` during the TX data bits and during RX data bits → `tx`=1 next cycle, `tx_busy`=0, no RX strobes. A following 0x7E loopback is received correctly.
